// File: rtl/id_pkg.sv
// Shared types for the instruction-decode stage: RV32I opcodes, ALU/comparator
// encodings and the packed control bundle handed to execute.
package id_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor,
    AluSrl, AluSra, AluOr, AluAnd, AluPassB
  } alu_op_e;

  typedef enum logic [2:0] {
    CmpNone, CmpEq, CmpNe, CmpLt, CmpGe, CmpLtu, CmpGeu
  } cmp_op_e;

  typedef enum logic [1:0] {PortaRs1, PortaPc, PortaZero} porta_sel_e;
  typedef enum logic [1:0] {PortbRs2, PortbImm, PortbFour} portb_sel_e;

  typedef struct packed {
    alu_op_e    alu_op;
    cmp_op_e    comparator_op;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_byte;
    logic       mem_halfword;
    logic       mem_unsigned;
    logic       mem_ex_sel;
    porta_sel_e porta_sel;
    portb_sel_e portb_sel;
    logic       branch_op;
    logic       jump_op;
    logic       syscall_op;
    logic       break_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    return (opc == OPC_LUI)    || (opc == OPC_AUIPC)  || (opc == OPC_JAL)   ||
           (opc == OPC_JALR)   || (opc == OPC_BRANCH) || (opc == OPC_LOAD)  ||
           (opc == OPC_STORE)  || (opc == OPC_OPIMM)  || (opc == OPC_OP)    ||
           (opc == OPC_MISCMEM) || (opc == OPC_SYSTEM);
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: register fields, 32-bit immediate and control bundle.
module id_decoder
  import id_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [31:0] o_imm,
  output ctrl_t       o_ctrl,
  output logic        o_illegal
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_f7b5;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_f7b5   = i_instr[30];
  assign o_rd     = i_instr[11:7];
  assign o_rs1    = i_instr[19:15];
  assign o_rs2    = i_instr[24:20];

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'h000};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

  assign o_illegal = !is_rv32i_opcode(w_opcode);

  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic f7b5,
                                              input logic allow_sub);
    case (f3)
      3'b000:  return (allow_sub && f7b5) ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return f7b5 ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

  always_comb begin
    o_ctrl = '0;
    o_imm  = '0;
    case (w_opcode)
      OPC_LUI: begin
        o_imm            = w_imm_u;
        o_ctrl.alu_op    = AluPassB;
        o_ctrl.porta_sel = PortaZero;
        o_ctrl.portb_sel = PortbImm;
        o_ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        o_imm            = w_imm_u;
        o_ctrl.porta_sel = PortaPc;
        o_ctrl.portb_sel = PortbImm;
        o_ctrl.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU produces the link value pc+4; the target uses the immediate.
        o_imm            = (w_opcode == OPC_JAL) ? w_imm_j : w_imm_i;
        o_ctrl.porta_sel = PortaPc;
        o_ctrl.portb_sel = PortbFour;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.jump_op   = 1'b1;
      end
      OPC_BRANCH: begin
        o_imm            = w_imm_b;
        o_ctrl.branch_op = 1'b1;
        case (w_funct3)
          3'b000:  o_ctrl.comparator_op = CmpEq;
          3'b001:  o_ctrl.comparator_op = CmpNe;
          3'b100:  o_ctrl.comparator_op = CmpLt;
          3'b101:  o_ctrl.comparator_op = CmpGe;
          3'b110:  o_ctrl.comparator_op = CmpLtu;
          3'b111:  o_ctrl.comparator_op = CmpGeu;
          default: o_ctrl.comparator_op = CmpNone;
        endcase
      end
      OPC_LOAD: begin
        o_imm               = w_imm_i;
        o_ctrl.portb_sel    = PortbImm;
        o_ctrl.reg_write    = 1'b1;
        o_ctrl.mem_read     = 1'b1;
        o_ctrl.mem_ex_sel   = 1'b1;
        o_ctrl.mem_byte     = (w_funct3[1:0] == 2'b00);
        o_ctrl.mem_halfword = (w_funct3[1:0] == 2'b01);
        o_ctrl.mem_unsigned = w_funct3[2];
      end
      OPC_STORE: begin
        o_imm               = w_imm_s;
        o_ctrl.portb_sel    = PortbImm;
        o_ctrl.mem_write    = 1'b1;
        o_ctrl.mem_byte     = (w_funct3[1:0] == 2'b00);
        o_ctrl.mem_halfword = (w_funct3[1:0] == 2'b01);
      end
      OPC_OPIMM: begin
        o_imm            = w_imm_i;
        o_ctrl.alu_op    = alu_from_funct3(w_funct3, w_f7b5, 1'b0);
        o_ctrl.portb_sel = PortbImm;
        o_ctrl.reg_write = 1'b1;
      end
      OPC_OP: begin
        o_ctrl.alu_op    = alu_from_funct3(w_funct3, w_f7b5, 1'b1);
        o_ctrl.reg_write = 1'b1;
      end
      OPC_SYSTEM: begin
        o_imm = w_imm_i;
        if (w_funct3 == 3'b000) begin
          o_ctrl.syscall_op = !i_instr[20];
          o_ctrl.break_op   = i_instr[20];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_queue.sv
// Circular FIFO of fetched {pc, instruction} entries; pointers wrap at DEPTH-1
// so any depth works, not just powers of two.
module id_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (i_push && !i_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!i_push && i_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/id_pipe_stage.sv
// Decode stage: fetch pushes into a small queue, the head is decoded and
// registered toward execute with a valid/ready handshake.
module id_pipe_stage
  import id_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned QDEPTH        = 4,
  parameter bit          CHECK_ILLEGAL = 1'b1,
  localparam int unsigned CNT_W        = $clog2(QDEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [31:0]       if_instruction,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              id_valid,
  output logic [XLEN-1:0]   id_pc,
  output logic [4:0]        id_rs1,
  output logic [4:0]        id_rs2,
  output logic [4:0]        id_rd,
  output logic [XLEN-1:0]   id_imm,
  output logic [CTRL_W-1:0] id_ctrl,
  output logic              id_illegal,
  output logic [CNT_W-1:0]  q_count
);

  logic [XLEN+31:0] w_q_wdata;
  logic [XLEN+31:0] w_q_rdata;
  logic             w_q_empty;
  logic             w_q_full;
  logic             w_push;
  logic             w_pop;
  logic [XLEN-1:0]  w_head_pc;
  logic [31:0]      w_head_instr;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [4:0]       w_rd;
  logic [31:0]      w_dec_imm;
  ctrl_t            w_dec_ctrl;
  logic             w_dec_illegal;
  ctrl_t            w_ctrl;
  logic             w_illegal;

  logic             r_id_valid;
  logic [XLEN-1:0]  r_id_pc;
  logic [4:0]       r_id_rs1;
  logic [4:0]       r_id_rs2;
  logic [4:0]       r_id_rd;
  logic [XLEN-1:0]  r_id_imm;
  ctrl_t            r_id_ctrl;
  logic             r_id_illegal;

  // Ready ignores a same-cycle pop so fetch never sees a combinational path from ex_ready.
  assign if_ready  = !rst && !flush && !w_q_full;
  assign w_push    = if_valid && if_ready;
  assign w_pop     = !w_q_empty && (!r_id_valid || ex_ready) && !flush;
  assign w_q_wdata = {if_pc, if_instruction};

  id_queue #(
    .WIDTH(XLEN + 32),
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_data  (w_q_wdata),
    .o_data  (w_q_rdata),
    .o_count (q_count),
    .o_empty (w_q_empty),
    .o_full  (w_q_full)
  );

  assign w_head_pc    = w_q_rdata[XLEN+31:32];
  assign w_head_instr = w_q_rdata[31:0];

  id_decoder u_decoder (
    .i_instr   (w_head_instr),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_rd      (w_rd),
    .o_imm     (w_dec_imm),
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_illegal)
  );

  // Illegal instructions still flow to execute, but with every side effect suppressed.
  always_comb begin
    w_ctrl    = w_dec_ctrl;
    w_illegal = 1'b0;
    if (CHECK_ILLEGAL && w_dec_illegal) begin
      w_illegal        = 1'b1;
      w_ctrl.reg_write = 1'b0;
      w_ctrl.mem_write = 1'b0;
      w_ctrl.mem_read  = 1'b0;
      w_ctrl.branch_op = 1'b0;
      w_ctrl.jump_op   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_id_rs1     <= '0;
      r_id_rs2     <= '0;
      r_id_rd      <= '0;
      r_id_imm     <= '0;
      r_id_ctrl    <= '0;
      r_id_illegal <= 1'b0;
    end else if (flush) begin
      r_id_valid <= 1'b0;
    end else if (w_pop) begin
      r_id_valid   <= 1'b1;
      r_id_pc      <= w_head_pc;
      r_id_rs1     <= w_rs1;
      r_id_rs2     <= w_rs2;
      r_id_rd      <= w_rd;
      r_id_imm     <= XLEN'($signed(w_dec_imm));
      r_id_ctrl    <= w_ctrl;
      r_id_illegal <= w_illegal;
    end else if (ex_ready) begin
      r_id_valid <= 1'b0;
    end
  end

  assign id_valid   = r_id_valid;
  assign id_pc      = r_id_pc;
  assign id_rs1     = r_id_rs1;
  assign id_rs2     = r_id_rs2;
  assign id_rd      = r_id_rd;
  assign id_imm     = r_id_imm;
  assign id_ctrl    = r_id_ctrl;
  assign id_illegal = r_id_illegal;

endmodule

// File: doc/id_pipe_stage.md
ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width of pc and imm (32 or 64).
REQ-002 The block SHALL have parameter QDEPTH, default 4, instruction queue depth (2..16, any integer).
REQ-003 The block SHALL have parameter CHECK_ILLEGAL, default 1, enabling illegal-opcode detection.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset:
 clk  in  1  single clock, all state updates on rising edge
 rst  in  1  asynchronous, active-high reset
 if_valid  in  1  fetch offers an instruction
 if_ready  out  1  queue accepts an instruction
 if_pc  in  XLEN  pc of offered instruction
 if_instruction  in  32  offered instruction word
 flush  in  1  discard all queued and held instructions
 ex_ready  in  1  execute stage accepts current output
 id_valid  out  1  decoded output valid
 id_pc  out  XLEN  pc of decoded instruction
 id_rs1, id_rs2, id_rd  out  5 each  register indices
 id_imm  out  XLEN  sign-extended immediate
 id_ctrl  out  CTRL_W  packed control bundle (alu_op, comparator_op, reg_write, mem_write, mem_read, mem_byte, mem_halfword, mem_unsigned, mem_ex_sel, porta_sel, portb_sel, branch_op, jump_op, syscall_op, break_op)
 id_illegal  out  1  decoded instruction is illegal
 q_count  out  clog2(QDEPTH+1)  queue occupancy

Function
REQ-005 Push SHALL occur when if_valid && if_ready; if_ready SHALL equal (q_count < QDEPTH) && !flush, independent of same-cycle pop.
REQ-006 Queue SHALL be FIFO of {pc, instruction}; read/write pointers SHALL wrap from QDEPTH-1 to 0 for non-power-of-two depths.
REQ-007 Queue head SHALL be decoded combinationally by the existing decoder; result SHALL load into the output register when queue non-empty && (!id_valid || ex_ready), popping the head.
REQ-008 Latency: instruction pushed at edge k into an empty queue with empty output register SHALL appear with id_valid=1 after edge k+1; sustained throughput SHALL be 1 instruction/cycle.
REQ-009 When id_valid && !ex_ready, all id_* outputs SHALL hold stable.
REQ-010 When id_valid && ex_ready && queue empty, id_valid SHALL clear at next edge.
REQ-011 Simultaneous push and pop SHALL leave q_count unchanged.
REQ-012 flush SHALL, at next edge, set q_count=0, pointers=0, id_valid=0; flush dominates push, pop and ex_ready.
REQ-013 id_imm SHALL be the decoder immediate sign-extended from bit 31 to XLEN.
REQ-014 With CHECK_ILLEGAL=1, an opcode outside RV32I base set SHALL give id_illegal=1, id_valid=1, and id_ctrl with reg_write, mem_write, mem_read, branch_op, jump_op forced 0; with CHECK_ILLEGAL=0 id_illegal SHALL be 0.

Reset
REQ-015 rst SHALL asynchronously clear pointers, q_count, id_valid, id_illegal, id_pc, id_rs1/rs2/rd, id_imm, id_ctrl to 0.
REQ-016 if_ready SHALL be 0 while rst is high and 1 in the first cycle after release.
REQ-017 Reset mid-stream SHALL drop all held instructions; no partial output SHALL appear after release.

Structure
REQ-018 Package id_pkg SHALL hold the ctrl bundle typedef, CTRL_W, RV32I opcode constants and alu_op/comparator_op encodings.
REQ-019 The queue SHALL be a sub-module id_queue (parameters WIDTH, DEPTH); decoder SHALL be instantiated unchanged.

Verification
REQ-020 Push 0x00500093 (addi x1,x0,5) at pc 0x100, ex_ready=1 -> after edge k+1: id_valid=1, id_pc=0x100, id_rd=1, id_rs1=0, id_imm=5, reg_write=1, mem_write=0.
REQ-021 QDEPTH=4, ex_ready=0, offer 6 instructions back-to-back -> 5 accepted (1 output, 4 queued), q_count=4, if_ready=0, outputs hold first; ex_ready=1 -> remaining 5 emerge in order, one per cycle.
REQ-022 QDEPTH=3, stream 10 instructions pc 0x0..0x24 with ex_ready toggling every cycle -> all 10 emerge in pc order, none lost/duplicated (pointer wrap).
REQ-023 Queue holding 3, flush with if_valid=1 same cycle -> next cycle q_count=0, id_valid=0, offered instruction not accepted.
REQ-024 Push 0x00000000 -> id_illegal=1, id_valid=1, reg_write=0, mem_write=0; push 0x00000073 (ecall) -> id_illegal=0, syscall_op=1.
REQ-025 XLEN=64, push 0xFFF00093 (addi x1,x0,-1) -> id_imm=0xFFFFFFFFFFFFFFFF; assert rst mid-stream -> all outputs 0 immediately, no stale output after release.
